// File: rtl/array_allocator.sv
// array_allocator: round-robin arbitrated allocator for heap array ids.
// Owns the allocation high-water counter and the LIFO stack of freed ids,
// and serves one alloc/free request at a time through IDLE -> SERVE -> ACK.
// A successful alloc also emits a one-cycle clear command for the array size.
// Optional feature: define ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN to keep an
// in-use bitmap that rejects frees of ids that are not currently allocated.
module array_allocator #(
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 2,
    parameter int NRequesters        = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NRequesters-1:0]                   req,
    input  logic [NRequesters-1:0]                   op,
    input  logic [NRequesters*MemoryElementWidth-1:0] freeId,
    output logic [NRequesters-1:0]                   ack,
    output logic [MemoryElementWidth-1:0]            ackId,
    output logic                                     ackError,
    output logic                                     sizeClearValid,
    output logic [MemoryElementWidth-1:0]            sizeClearId,
    output logic [MemoryElementWidth-1:0]            allocs,
    output logic [MemoryElementWidth-1:0]            inUse
);

    localparam int W    = MemoryElementWidth;
    localparam int IdxW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int RrW  = (NRequesters > 1) ? $clog2(NRequesters) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        ACK
    } stateT;

    stateT            stateQ, stateD;
    logic [RrW-1:0]   rrQ, rrD;
    logic [RrW-1:0]   winnerQ, winnerD;
    logic             opQ, opD;
    logic [W-1:0]     idQ, idD;
    logic [W-1:0]     allocsQ, allocsD;
    logic [W-1:0]     depthQ, depthD;
    logic [W-1:0]     resultQ, resultD;
    logic             errorQ, errorD;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    logic [NArrays-1:0] usedQ, usedD;
`endif

    logic [W-1:0]     stackQ [NArrays];
    logic             pushEn;
    logic [IdxW-1:0]  pushIdx;
    logic [W-1:0]     pushData;
    logic [W-1:0]     stackTop;

    logic [W-1:0]     freeIdArr [NRequesters];
    logic             found;
    int               cand;
    logic [RrW-1:0]   candIdx;
    logic             ackActive;

    // Split the flat freeId bus into one slice per requester.
    for (genvar k = 0; k < NRequesters; k++) begin : gSlice
        assign freeIdArr[k] = freeId[k*W +: W];
    end

    assign stackTop = stackQ[IdxW'(depthQ - 1'b1)];

    // State register and all allocator bookkeeping, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ  <= IDLE;
            rrQ     <= '0;
            winnerQ <= '0;
            opQ     <= 1'b0;
            idQ     <= '0;
            allocsQ <= '0;
            depthQ  <= '0;
            resultQ <= '0;
            errorQ  <= 1'b0;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
            usedQ   <= '0;
`endif
        end else begin
            stateQ  <= stateD;
            rrQ     <= rrD;
            winnerQ <= winnerD;
            opQ     <= opD;
            idQ     <= idD;
            allocsQ <= allocsD;
            depthQ  <= depthD;
            resultQ <= resultD;
            errorQ  <= errorD;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
            usedQ   <= usedD;
`endif
        end
    end

    // Stack storage needs no reset: a zero depth makes every entry dead.
    always_ff @(posedge clock) begin
        if (pushEn) begin
            stackQ[pushIdx] <= pushData;
        end
    end

    // Next-state logic: arbitration in IDLE, the alloc/free decision in SERVE,
    // and round-robin pointer advance in ACK.
    always_comb begin
        stateD   = stateQ;
        rrD      = rrQ;
        winnerD  = winnerQ;
        opD      = opQ;
        idD      = idQ;
        allocsD  = allocsQ;
        depthD   = depthQ;
        resultD  = resultQ;
        errorD   = errorQ;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
        usedD    = usedQ;
`endif
        pushEn   = 1'b0;
        pushIdx  = IdxW'(depthQ);
        pushData = idQ;
        found    = 1'b0;
        cand     = 0;
        candIdx  = '0;

        case (stateQ)
            IDLE: begin
                if (|req) begin
                    for (int i = 0; i < NRequesters; i++) begin
                        cand    = (int'(rrQ) + i) % NRequesters;
                        candIdx = RrW'(cand);
                        if (!found && req[candIdx]) begin
                            found   = 1'b1;
                            winnerD = candIdx;
                            opD     = op[candIdx];
                            idD     = freeIdArr[candIdx];
                        end
                    end
                    stateD = SERVE;
                end
            end

            SERVE: begin
                errorD  = 1'b0;
                resultD = '0;
                if (!opQ) begin
                    if (depthQ != '0) begin
                        resultD = stackTop;
                        depthD  = depthQ - 1'b1;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
                        usedD[IdxW'(stackTop)] = 1'b1;
`endif
                    end else if (allocsQ < W'(NArrays)) begin
                        resultD = allocsQ;
                        allocsD = allocsQ + 1'b1;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
                        usedD[IdxW'(allocsQ)] = 1'b1;
`endif
                    end else begin
                        errorD = 1'b1;
                    end
                end else begin
                    if (idQ >= allocsQ) begin
                        errorD = 1'b1;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
                    end else if (!usedQ[IdxW'(idQ)]) begin
                        errorD = 1'b1;
`endif
                    end else if (depthQ == W'(NArrays)) begin
                        errorD = 1'b1;
                    end else begin
                        pushEn = 1'b1;
                        depthD = depthQ + 1'b1;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
                        usedD[IdxW'(idQ)] = 1'b0;
`endif
                    end
                end
                stateD = ACK;
            end

            ACK: begin
                if (int'(winnerQ) == NRequesters - 1) begin
                    rrD = '0;
                end else begin
                    rrD = winnerQ + 1'b1;
                end
                stateD = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state so they are glitch-free and zero outside ACK.
    always_comb begin
        ackActive      = (stateQ == ACK);
        ack            = ackActive ? (NRequesters'(1) << winnerQ) : '0;
        ackId          = ackActive ? resultQ : '0;
        ackError       = ackActive & errorQ;
        sizeClearValid = ackActive & ~opQ & ~errorQ;
        sizeClearId    = sizeClearValid ? resultQ : '0;
        allocs         = allocsQ;
        inUse          = allocsQ - depthQ;
    end

endmodule

// File: tb/tb_array_allocator.sv
// tb_array_allocator: directed bench for array_allocator with NArrays=2,
// NRequesters=2. Honors ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN when defined.
module tb_array_allocator;

    localparam int W  = 12;
    localparam int NA = 2;
    localparam int NR = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR-1:0]   op;
    logic [NR*W-1:0] freeId;
    logic [NR-1:0]   ack;
    logic [W-1:0]    ackId;
    logic            ackError;
    logic            sizeClearValid;
    logic [W-1:0]    sizeClearId;
    logic [W-1:0]    allocs;
    logic [W-1:0]    inUse;

    int vectors     = 0;
    int miscompares = 0;

    array_allocator #(
        .MemoryElementWidth(W),
        .NArrays(NA),
        .NRequesters(NR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .op(op),
        .freeId(freeId),
        .ack(ack),
        .ackId(ackId),
        .ackError(ackError),
        .sizeClearValid(sizeClearValid),
        .sizeClearId(sizeClearId),
        .allocs(allocs),
        .inUse(inUse)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitAck(output int cycles);
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
        end while (ack == '0 && cycles < 8);
    endtask

    task automatic doReset();
        reset  = 1'b1;
        req    = '0;
        op     = '0;
        freeId = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int r, input logic o, input logic [W-1:0] id,
                                 input logic [W-1:0] expId, input logic expErr,
                                 input logic [W-1:0] expInUse, input string tag);
        int   cyc;
        logic expClear;
        expClear = !o && !expErr;
        req[r]   = 1'b1;
        op[r]    = o;
        freeId[r*W +: W] = id;
        waitAck(cyc);
        checkOutput({tag, " latency"}, cyc, 2);
        checkOutput({tag, " ack"}, ack, 32'(1) << r);
        checkOutput({tag, " ackId"}, ackId, expId);
        checkOutput({tag, " ackError"}, ackError, expErr);
        checkOutput({tag, " sizeClearValid"}, sizeClearValid, expClear);
        checkOutput({tag, " sizeClearId"}, sizeClearId, expClear ? expId : '0);
        checkOutput({tag, " inUse"}, inUse, expInUse);
        @(posedge clock);
        #1;
        req[r] = 1'b0;
        checkOutput({tag, " ackDrop"}, ack, 0);
    endtask

    task automatic applyPair(input logic [1:0] o, input logic [W-1:0] id0, input logic [W-1:0] id1,
                             input int first, input logic [W-1:0] expFirst,
                             input logic [W-1:0] expSecond, input string tag);
        int cyc;
        int second;
        second = 1 - first;
        op     = o;
        freeId = {id1, id0};
        req    = 2'b11;
        waitAck(cyc);
        checkOutput({tag, " firstLatency"}, cyc, 2);
        checkOutput({tag, " firstAck"}, ack, 32'(1) << first);
        checkOutput({tag, " firstId"}, ackId, expFirst);
        checkOutput({tag, " firstErr"}, ackError, 0);
        @(posedge clock);
        #1;
        req[first] = 1'b0;
        waitAck(cyc);
        checkOutput({tag, " secondLatency"}, cyc, 2);
        checkOutput({tag, " secondAck"}, ack, 32'(1) << second);
        checkOutput({tag, " secondId"}, ackId, expSecond);
        checkOutput({tag, " secondErr"}, ackError, 0);
        @(posedge clock);
        #1;
        req[second] = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("reset ack", ack, 0);
        checkOutput("reset ackId", ackId, 0);
        checkOutput("reset ackError", ackError, 0);
        checkOutput("reset sizeClearValid", sizeClearValid, 0);
        checkOutput("reset sizeClearId", sizeClearId, 0);
        checkOutput("reset allocs", allocs, 0);
        checkOutput("reset inUse", inUse, 0);

        // Exhaust the id space.
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 1, "alloc0");
        applyStimulus(0, 1'b0, 0, 1, 1'b0, 2, "alloc1");
        applyStimulus(0, 1'b0, 0, 0, 1'b1, 2, "allocFull");
        checkOutput("full allocs", allocs, 2);
        checkOutput("full inUse", inUse, 2);

        // LIFO reuse of freed ids.
        doReset();
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 1, "lifoAlloc0");
        applyStimulus(0, 1'b0, 0, 1, 1'b0, 2, "lifoAlloc1");
        applyStimulus(0, 1'b1, 1, 0, 1'b0, 1, "lifoFree1");
        applyStimulus(0, 1'b1, 0, 0, 1'b0, 0, "lifoFree0");
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 1, "lifoRealloc0");
        applyStimulus(0, 1'b0, 0, 1, 1'b0, 2, "lifoRealloc1");
        checkOutput("lifo allocs", allocs, 2);

        // Double free of the same id.
        doReset();
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 1, "dblAlloc0");
        applyStimulus(0, 1'b0, 0, 1, 1'b0, 2, "dblAlloc1");
        applyStimulus(0, 1'b1, 0, 0, 1'b0, 1, "dblFree0");
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
        applyStimulus(0, 1'b1, 0, 0, 1'b1, 1, "dblFreeAgain");
`else
        applyStimulus(0, 1'b1, 0, 0, 1'b0, 0, "dblFreeAgain");
        applyStimulus(0, 1'b1, 0, 0, 1'b1, 0, "dblFreeStackFull");
`endif

        // Free of an id never handed out.
        doReset();
        applyStimulus(1, 1'b1, 5, 0, 1'b1, 0, "freeBad");
        checkOutput("freeBad allocs", allocs, 0);

        // Reset during SERVE discards the operation.
        doReset();
        req[0] = 1'b1;
        op[0]  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midReset ack", ack, 0);
        checkOutput("midReset allocs", allocs, 0);
        reset = 1'b0;
        req   = '0;
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 1, "afterReset");

        // Round-robin arbitration between two held requests.
        doReset();
        applyPair(2'b00, 0, 0, 0, 0, 1, "bothAlloc");
        applyPair(2'b11, 0, 1, 0, 0, 0, "bothFree");
        applyPair(2'b00, 0, 0, 0, 1, 0, "bothRealloc");
        applyStimulus(0, 1'b1, 5, 0, 1'b1, 2, "r0BadFree");
        applyPair(2'b11, 0, 1, 1, 0, 0, "rotFree");
        checkOutput("rot inUse", inUse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
